axis_event_arbiter: RTL and testbench

//  Round-robin arbiter merging C_NUM_SI AXI-Stream event sources into one stream for the

---
 rtl/axis_event_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axis_event_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_event_arbiter.sv
// Round-robin AXI-Stream event arbiter with bounded bursts and a registered, source-tagged output.
// Optional per-source beat counters on stat_beats when AXIS_ARB_STATS_EN is defined.
module axis_event_arbiter #(
  parameter int unsigned C_NUM_SI           = 4,
  parameter int unsigned C_AXIS_TDATA_WIDTH = 96,
  parameter int unsigned C_MAX_BURST        = 16,
  parameter int unsigned C_TID_WIDTH        = 2
) (
  input  logic                                     aclk,
  input  logic                                     aresetn,
  input  logic [C_NUM_SI-1:0]                      s_axis_tvalid,
  output logic [C_NUM_SI-1:0]                      s_axis_tready,
  input  logic [C_NUM_SI*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
`ifdef AXIS_ARB_STATS_EN
  output logic [C_NUM_SI*32-1:0]                   stat_beats,
`endif
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_TID_WIDTH-1:0]                   m_axis_tid
);

  localparam int unsigned BurstW = $clog2(C_MAX_BURST + 1);
  localparam int unsigned W      = C_AXIS_TDATA_WIDTH;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                  state_q, state_d;
  logic [C_TID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [C_TID_WIDTH-1:0]  grant_q, grant_d;
  logic [BurstW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                    tvalid_q, tvalid_d;
  logic [W-1:0]            tdata_q, tdata_d;
  logic [C_TID_WIDTH-1:0]  tid_q, tid_d;

  logic                    out_free;
  logic                    sel_valid;
  logic [W-1:0]            sel_data;
  logic                    accept;
  logic                    pick_found;
  logic [C_TID_WIDTH-1:0]  pick_idx;
  logic [C_TID_WIDTH-1:0]  next_ptr;
  int unsigned             cand;

  assign out_free = !tvalid_q || m_axis_tready;
  assign accept   = (state_q == StGrant) && sel_valid && out_free;
  assign next_ptr = (grant_q == C_TID_WIDTH'(C_NUM_SI - 1)) ? '0 : grant_q + C_TID_WIDTH'(1);

  // Mux the granted source and drive per-source ready.
  always_comb begin
    sel_valid     = 1'b0;
    sel_data      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < int'(C_NUM_SI); i++) begin
      if (grant_q == C_TID_WIDTH'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_data         = s_axis_tdata[i*W +: W];
        s_axis_tready[i] = (state_q == StGrant) && out_free;
      end
    end
  end

  // First requester at the smallest distance from rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int d = 0; d < int'(C_NUM_SI); d++) begin
      cand = (int'(rr_ptr_q) + d) % C_NUM_SI;
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = C_TID_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tid_d       = tid_q;

    if (accept) begin
      tvalid_d = 1'b1;
      tdata_d  = sel_data;
      tid_d    = grant_q;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = StGrant;
        end
      end
      StGrant: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + BurstW'(1);
          if (burst_cnt_q == BurstW'(C_MAX_BURST - 1)) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end
        end else if (out_free && !sel_valid) begin
          // Release only when the output can move; backpressure keeps the grant.
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tid_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tid_q       <= tid_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tid    = tid_q;

`ifdef AXIS_ARB_STATS_EN
  logic [31:0] stat_q [C_NUM_SI];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(C_NUM_SI); i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(C_NUM_SI); i++) begin
        if (accept && (grant_q == C_TID_WIDTH'(i)) && (stat_q[i] != 32'hFFFF_FFFF)) begin
          stat_q[i] <= stat_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < int'(C_NUM_SI); i++) stat_beats[i*32 +: 32] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_axis_event_arbiter.sv
// Randomised and directed bench for axis_event_arbiter against a transaction-level model.
module tb_axis_event_arbiter;
  localparam int N    = 4;
  localparam int W    = 96;
  localparam int MAXB = 4;
  localparam int TIDW = 2;

  localparam logic [W-1:0] D0 = 96'hD0D0_0000_1111_2222_3333_0000;
  localparam logic [W-1:0] D1 = 96'hD1D1_0000_4444_5555_6666_0001;
  localparam logic [W-1:0] D2 = 96'hD2D2_0000_7777_8888_9999_0002;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic             aresetn;
  logic [N-1:0]     s_axis_tvalid;
  logic [N-1:0]     s_axis_tready;
  logic [N*W-1:0]   s_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [W-1:0]     m_axis_tdata;
  logic [TIDW-1:0]  m_axis_tid;
`ifdef AXIS_ARB_STATS_EN
  logic [N*32-1:0]  stat_beats;
`endif

  axis_event_arbiter #(
    .C_NUM_SI(N), .C_AXIS_TDATA_WIDTH(W), .C_MAX_BURST(MAXB), .C_TID_WIDTH(TIDW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
`ifdef AXIS_ARB_STATS_EN
    .stat_beats(stat_beats),
`endif
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid)
  );

  int checks = 0;
  int errors = 0;

  // Model: who owns the output, how many beats of the burst remain, where the search starts next.
  bit           mb_busy;
  int           m_owner, m_ptr, m_left;
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_otid;
  int unsigned  m_stat [N];

  logic [W-1:0] src_q [N][$];
  bit           pres [N];
  bit           rst_req, rdy_val, rand_mode, cmp_en;
  int           cyc;
  int           seen_tid [$];
  int           seen_cyc [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] exp_tready();
    logic [N-1:0] r = '0;
    if (mb_busy && (!m_ov || m_axis_tready)) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    mb_busy = 0; m_owner = 0; m_ptr = 0; m_left = 0;
    m_ov = 0; m_od = '0; m_otid = 0;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
  endtask

  task automatic model_step();
    bit free;
    bit found;
    free = !m_ov || m_axis_tready;
    if (!aresetn) begin
      model_reset();
    end else if (!mb_busy) begin
      found = 0;
      for (int d = 0; d < N; d++) begin
        if (!found && s_axis_tvalid[(m_ptr + d) % N]) begin
          found = 1; m_owner = (m_ptr + d) % N;
        end
      end
      if (found) begin mb_busy = 1; m_left = MAXB; end
      if (m_axis_tready) m_ov = 0;
    end else if (s_axis_tvalid[m_owner] && free) begin
      m_od = s_axis_tdata[m_owner*W +: W];
      m_otid = m_owner;
      m_ov = 1;
      if (m_stat[m_owner] != 32'hFFFF_FFFF) m_stat[m_owner]++;
      m_left--;
      if (m_left == 0) begin mb_busy = 0; m_ptr = (m_owner + 1) % N; end
    end else begin
      if (m_axis_tready) m_ov = 0;
      if (free && !s_axis_tvalid[m_owner]) begin mb_busy = 0; m_ptr = (m_owner + 1) % N; end
    end
  endtask

  task automatic compare();
    chk("s_tready", s_axis_tready, exp_tready());
    chk("m_tvalid", m_axis_tvalid, m_ov);
    chk("m_tdata", m_axis_tdata, m_od);
    chk("m_tid", m_axis_tid, m_otid);
`ifdef AXIS_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("stat%0d", i), stat_beats[i*32 +: 32], m_stat[i]);
`endif
  endtask

  task automatic tick_begin();
    @(negedge aclk);
    aresetn = !rst_req;
    m_axis_tready = rand_mode ? ($urandom_range(0, 99) < 70) : rdy_val;
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && src_q[i].size() > 0 && (!rand_mode || $urandom_range(0, 3) != 0))
        pres[i] = 1;
      s_axis_tvalid[i] = pres[i];
      s_axis_tdata[i*W +: W] = pres[i] ? src_q[i][0] : '0;
    end
    #1;
    if (cmp_en) compare();
    if (m_axis_tvalid && m_axis_tready && aresetn) begin
      seen_tid.push_back(int'(m_axis_tid));
      seen_cyc.push_back(cyc);
    end
  endtask

  task automatic tick_end();
    logic [N-1:0] tr;
    tr = exp_tready();
    model_step();
    for (int i = 0; i < N; i++) begin
      if (pres[i] && tr[i]) begin
        void'(src_q[i].pop_front());
        pres[i] = 0;
      end
    end
  endtask

  task automatic step();
    tick_end();
    cyc++;
    tick_begin();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin src_q[i].delete(); pres[i] = 0; end
    rst_req = 1;
    repeat (2) step();
    rst_req = 0;
    step();
    seen_tid.delete();
    seen_cyc.delete();
  endtask

  function automatic bit busy_src();
    bit b = m_axis_tvalid;
    for (int i = 0; i < N; i++) if (pres[i] || src_q[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while (busy_src() && n < maxc) begin step(); n++; end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_timeout: got %0d cycles required < %0d", name, n, maxc);
    end
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int n = 0;
    while (!m_axis_tvalid && n < maxc) begin step(); n++; end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s_wait: got %0d cycles required < %0d", name, n, maxc);
    end
  endtask

  initial begin
    int exp2 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    cyc = 0; cmp_en = 0; rand_mode = 0; rdy_val = 1; rst_req = 1;
    m_axis_tready = 1; s_axis_tvalid = '0; s_axis_tdata = '0; aresetn = 0;
    for (int i = 0; i < N; i++) pres[i] = 0;
    model_reset();
    tick_begin();
    step();
    step();
    cmp_en = 1;
    rst_req = 0;
    step();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tid", m_axis_tid, 0);
    chk("rst_tready", s_axis_tready, 0);

    // Single source, three beats, two-cycle latency.
    src_q[0].push_back(D0); src_q[0].push_back(D1); src_q[0].push_back(D2);
    step(); chk("t1_idle_tready", s_axis_tready, 4'b0000);
    step(); chk("t1_grant_tready", s_axis_tready, 4'b0001); chk("t1_noval", m_axis_tvalid, 0);
    step(); chk("t1_v0", m_axis_tvalid, 1); chk("t1_d0", m_axis_tdata, D0); chk("t1_tid0", m_axis_tid, 0);
    step(); chk("t1_d1", m_axis_tdata, D1);
    step(); chk("t1_d2", m_axis_tdata, D2);
    step(); chk("t1_end", m_axis_tvalid, 0);
    chk("t1_ptr", m_ptr, 1);

    // Two always-valid sources: bursts of MAXB with one bubble per switch.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      src_q[0].push_back({32'h0, 32'h0, k[31:0]});
      src_q[1].push_back({32'h1, 32'h0, k[31:0]});
    end
    drain("t2", 200);
    chk("t2_len", seen_tid.size(), 12);
    for (int k = 0; k < 12 && k < seen_tid.size(); k++) chk($sformatf("t2_tid%0d", k), seen_tid[k], exp2[k]);
    if (seen_cyc.size() > 4) chk("t2_bubble", seen_cyc[4] - seen_cyc[3], 2);

    // Backpressure holds output and keeps the grant.
    do_reset();
    src_q[2].push_back(D0); src_q[2].push_back(D1); src_q[2].push_back(D2);
    wait_valid("t3", 10);
    rdy_val = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_v", m_axis_tvalid, 1); chk("t3_d", m_axis_tdata, D1);
      chk("t3_tid", m_axis_tid, 2); chk("t3_tready", s_axis_tready, 4'b0000);
    end
    rdy_val = 1;
    drain("t3", 50);

    // Early release by an idle source hands over to the next requester.
    do_reset();
    src_q[1].push_back(D0); src_q[3].push_back(D1); src_q[3].push_back(D2);
    wait_valid("t4", 10);
    chk("t4_first", m_axis_tid, 1);
    step();
    chk("t4_ptr", m_ptr, 2); chk("t4_idle", s_axis_tready, 4'b0000);
    drain("t4", 50);
    chk("t4_len", seen_tid.size(), 3);
    if (seen_tid.size() == 3) begin
      chk("t4_s1", seen_tid[1], 3); chk("t4_s2", seen_tid[2], 3);
    end

    // Reset in the middle of a burst.
    do_reset();
    for (int k = 0; k < 8; k++) src_q[0].push_back({64'hA5, k[31:0]});
    while (seen_tid.size() < 3 && cyc < 2000) step();
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    chk("t5_v", m_axis_tvalid, 0); chk("t5_d", m_axis_tdata, 0); chk("t5_tid", m_axis_tid, 0);
    chk("t5_tready", s_axis_tready, 4'b0000); chk("t5_ptr", m_ptr, 0);
    drain("t5", 100);

`ifdef AXIS_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 7; k++) src_q[0].push_back({64'h0, k[31:0]});
    for (int k = 0; k < 5; k++) src_q[3].push_back({64'h3, k[31:0]});
    drain("t6", 200);
    chk("t6_s0", stat_beats[31:0], 7); chk("t6_s1", stat_beats[63:32], 0);
    chk("t6_s2", stat_beats[95:64], 0); chk("t6_s3", stat_beats[127:96], 5);
`endif

    // Random traffic, backpressure and occasional resets.
    do_reset();
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 6 && $urandom_range(0, 3) == 0)
          src_q[i].push_back({$urandom, $urandom, $urandom});
      rst_req = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_req = 0;
    rand_mode = 0;
    drain("rand", 500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
